serial_mag_compare_ctrl: RTL and testbench



---
 rtl/fpu_div_pkg.sv | 21 ++
 rtl/COMP_UNIT.sv | 26 ++
 rtl/serial_mag_compare_ctrl.sv | 115 +++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the divider datapath sequencers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_div_pkg;

  // Sequencer states for the serial comparator.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Comparator cell state encoding: {gt, lt}. 2'b11 never occurs.
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b10;
  localparam logic [1:0] CMP_LT = 2'b01;

  // Single-precision mantissa width including the hidden bit.
  localparam int MANT_WIDTH = 24;

endpackage

// File: rtl/COMP_UNIT.sv
// Bit-serial magnitude comparator cell; one operand bit pair per call, MSB first.
// Latency: purely combinational, the caller holds the cell state register.
// Backpressure: none; the caller decides when to register c_next.
// Ports: a, b - current operand bits; c - cell state in; c_next - cell state out.
module COMP_UNIT
  import fpu_div_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] c,
  output logic [1:0] c_next
);

  // Sticky: the first differing bit (MSB-first) decides the whole compare.
  always_comb begin
    c_next = c;
    if (c == CMP_EQ) begin
      if (a & ~b) begin
        c_next = CMP_GT;
      end else if (~a & b) begin
        c_next = CMP_LT;
      end
    end
  end

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Sequencer comparing two unsigned WIDTH-bit operands MSB-first through one COMP_UNIT cell.
// Latency: WIDTH+1 cycles start->done (fewer with EARLY_EXIT at the first differing bit).
// Backpressure: none; start is only accepted in IDLE/DONE and ignored while busy.
// Ports: clk, rst (sync, active-high); start, a, b in; busy, done, gt, lt, eq out.
module serial_mag_compare_ctrl
  import fpu_div_pkg::*;
#(
  parameter int WIDTH      = MANT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb;
  logic [1:0]       c, c_next;
  logic [CW-1:0]    cnt;
  logic             load, step, finish;

  COMP_UNIT u_cell (
    .a      (sa[WIDTH-1]),
    .b      (sb[WIDTH-1]),
    .c      (c),
    .c_next (c_next)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        // Leave after the LSB, or as soon as the cell has decided.
        if ((cnt == '0) || (EARLY_EXIT && (c_next != CMP_EQ))) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      c    <= CMP_EQ;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
    end else begin
      busy <= (state_next == ST_RUN);
      done <= finish;
      if (load) begin
        sa  <= a;
        sb  <= b;
        c   <= CMP_EQ;
        cnt <= CW'(WIDTH - 1);
      end else if (step) begin
        c  <= c_next;
        sa <= {sa[WIDTH-2:0], 1'b0};
        sb <= {sb[WIDTH-2:0], 1'b0};
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end
      end
      // Results are taken straight from the cell output so they are valid
      // in the same cycle done is high, and held until the next finish.
      if (finish) begin
        gt <= c_next[1];
        lt <= c_next[0];
        eq <= (c_next == CMP_EQ);
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
module tb_serial_mag_compare_ctrl;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;

  // Index 0: fixed latency instance, index 1: early-exit instance.
  logic busy_w[2], done_w[2], gt_w[2], lt_w[2], eq_w[2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_mag_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_fixed (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .gt(gt_w[0]), .lt(lt_w[0]), .eq(eq_w[0])
  );

  serial_mag_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .gt(gt_w[1]), .lt(lt_w[1]), .eq(eq_w[1])
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycles spent in RUN: full width, or up to the highest differing bit.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    if (!ee || x == y) return W;
    for (int k = W - 1; k >= 0; k--) begin
      if (x[k] != y[k]) return W - k;
    end
    return W;
  endfunction

  int m_st[2];   // 0 idle, 1 comparing, 2 result cycle
  int m_rem[2];
  bit m_pgt[2], m_plt[2], m_gt[2], m_lt[2], m_eq[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] = 0; m_rem[i] = 0;
        m_gt[i] = 1'b0; m_lt[i] = 1'b0; m_eq[i] = 1'b0;
      end else if (m_st[i] == 1) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_st[i] = 2;
          m_gt[i] = m_pgt[i];
          m_lt[i] = m_plt[i];
          m_eq[i] = !(m_pgt[i] || m_plt[i]);
        end
      end else if (start) begin
        m_st[i]  = 1;
        m_rem[i] = exp_lat(a, b, i == 1);
        m_pgt[i] = (a > b);
        m_plt[i] = (a < b);
      end else begin
        m_st[i] = 0;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i), busy_w[i], m_st[i] == 1);
        chk($sformatf("done[%0d]", i), done_w[i], m_st[i] == 2);
        chk($sformatf("gt[%0d]", i), gt_w[i], m_gt[i]);
        chk($sformatf("lt[%0d]", i), lt_w[i], m_lt[i]);
        chk($sformatf("eq[%0d]", i), eq_w[i], m_eq[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge where done[sel] is seen.
  // lat counts cycles from the start-sampling edge to the done cycle inclusive.
  task automatic run_cmp(input logic [W-1:0] xa, input logic [W-1:0] xb, input int sel,
                         input int pulse_at, input logic [W-1:0] pa, input logic [W-1:0] pb,
                         output int lat, output int bcnt);
    a = xa; b = xb; start = 1'b1;
    lat = 0; bcnt = 0;
    for (int g = 0; g < 40; g++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (lat == pulse_at) begin
        a = pa; b = pb; start = 1'b1;
      end
      if (busy_w[sel]) bcnt++;
      if (done_w[sel]) return;
    end
    total++; bad++;
    $display("FAIL timeout waiting for done[%0d]", sel);
  endtask

  task automatic settle();
    for (int g = 0; g < 40; g++) begin
      if (!busy_w[0] && !busy_w[1] && !done_w[0] && !done_w[1]) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  int lat, bc;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy_w[1], 1'b0);
    chk("reset done", done_w[1], 1'b0);
    chk("reset eq", eq_w[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Equal operands: full width even with early exit.
    run_cmp(24'hABCDEF, 24'hABCDEF, 1, 0, '0, '0, lat, bc);
    chk_int("eq latency", lat, 25);
    chk_int("eq busy cycles", bc, 24);
    chk("eq result", eq_w[1], 1'b1);
    chk("eq gt", gt_w[1], 1'b0);
    chk("eq lt", lt_w[1], 1'b0);
    settle();

    // MSB differs: early exit after one bit.
    run_cmp(24'h800000, 24'h7FFFFF, 1, 0, '0, '0, lat, bc);
    chk_int("msb early latency", lat, 2);
    chk("msb early gt", gt_w[1], 1'b1);
    settle();
    run_cmp(24'h800000, 24'h7FFFFF, 0, 0, '0, '0, lat, bc);
    chk_int("msb fixed latency", lat, 25);
    chk("msb fixed gt", gt_w[0], 1'b1);
    settle();

    // LSB differs.
    run_cmp(24'h000000, 24'h000001, 0, 0, '0, '0, lat, bc);
    chk_int("lsb latency", lat, 25);
    chk("lsb lt", lt_w[0], 1'b1);
    settle();
    chk("lsb lt early", lt_w[1], 1'b1);

    // start pulsed mid-compare with different operands is ignored.
    run_cmp(24'h123456, 24'h123456, 1, 5, 24'hFFFFFF, 24'h000000, lat, bc);
    chk_int("midrun latency", lat, 25);
    chk("midrun eq", eq_w[1], 1'b1);
    settle();

    // Reset in the 10th RUN cycle.
    run_cmp(24'h000010, 24'h000020, 0, 0, '0, '0, lat, bc);
    settle();
    a = 24'h000010; b = 24'h000020; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy_w[0], 1'b0);
    chk("abort done", done_w[1], 1'b0);
    chk("abort lt", lt_w[0], 1'b0);
    chk("abort lt early", lt_w[1], 1'b0);
    @(negedge clk);
    run_cmp(24'h000005, 24'h000005, 0, 0, '0, '0, lat, bc);
    chk_int("post-reset latency", lat, 25);
    chk("post-reset eq", eq_w[0], 1'b1);
    settle();

    // Back-to-back: start held in the DONE cycle.
    run_cmp(24'h800000, 24'h7FFFFF, 1, 0, '0, '0, lat, bc);
    chk_int("b2b first latency", lat, 2);
    run_cmp(24'h000100, 24'h000200, 1, 0, '0, '0, lat, bc);
    chk_int("b2b second latency", lat, 16);
    chk("b2b second lt", lt_w[1], 1'b1);
    chk("b2b second gt", gt_w[1], 1'b0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
